// File: rtl/fpmul_share_ctrl.sv
// Round-robin sequencer sharing one combinational fp32 multiplier
// between NREQ requesters; one operation in flight at a time.
module fpmul_share_ctrl #(
  parameter int NREQ = 2,
  parameter int IDW  = 1,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic [31:0]          mul_r,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_data,
  output logic [IDW-1:0]       resp_id,
  output logic                 busy,
  output logic [CNTW-1:0]      ops_done
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [IDW-1:0] last;
  logic [IDW-1:0] id;
  logic [IDW-1:0] gnt;
  logic [IDW-1:0] cand;
  logic           gnt_v;
  logic           xfer;

  // Scan downward so the nearest requester after last wins.
  always_comb begin
    gnt   = '0;
    gnt_v = 1'b0;
    cand  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDW'((int'(last) + k) % NREQ);
      if (req_valid[cand]) begin
        gnt   = cand;
        gnt_v = 1'b1;
      end
    end
  end

  assign xfer = (state == IDLE) && gnt_v && !reset;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (xfer) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    busy      = (state != IDLE);
    if (xfer) req_ready = NREQ'(1) << gnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last       <= IDW'(NREQ - 1);
      id         <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      ops_done   <= '0;
    end else begin
      if (xfer) begin
        mul_a <= req_a[32*gnt +: 32];
        mul_b <= req_b[32*gnt +: 32];
        id    <= gnt;
        last  <= gnt;
      end
      if (state == EXEC) begin
        resp_data  <= mul_r;
        resp_id    <= id;
        resp_valid <= 1'b1;
      end
      if (state == RESP && resp_ready) begin
        resp_valid <= 1'b0;
        ops_done   <= ops_done + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fpmul_share_ctrl.sv
// Bench for fpmul_share_ctrl: scenario tasks plus a
// grant/response scoreboard running alongside them.
module tb_fpmul_share_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] mul_r;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [0:0]  resp_id;
  logic        busy;
  logic [3:0]  ops_done;

  int checks = 0;
  int errors = 0;
  int exp_ops = 0;
  int m_last = 1;
  logic [32:0] sbq[$];

  always #5 clk = ~clk;

  // Stand-in multiplier: exact for the known vectors, a mixer otherwise.
  function automatic logic [31:0] fmodel(input logic [31:0] a,
                                         input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4000_0000;
    if (a == 32'h4040_0000 && b == 32'h4000_0000) return 32'h40C0_0000;
    return a ^ {b[15:0], b[31:16]};
  endfunction

  assign mul_r = fmodel(mul_a, mul_b);

  fpmul_share_ctrl #(
    .NREQ(2),
    .IDW (1),
    .CNTW(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_r     (mul_r),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_id   (resp_id),
    .busy      (busy),
    .ops_done  (ops_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int waited);
    waited = 0;
    #1;
    while (req_ready == 2'b00 && waited < 8) begin
      step();
      waited++;
    end
  endtask

  task automatic wait_resp(output int waited);
    waited = 0;
    #1;
    while (!resp_valid && waited < 8) begin
      step();
      waited++;
    end
  endtask

  task automatic sb_monitor();
    forever begin
      @(negedge clk);
      if (reset) begin
        sbq.delete();
        m_last  = 1;
        exp_ops = 0;
      end else begin
        if ((req_valid & req_ready) != 2'b00) begin
          int g;
          bit f;
          logic [1:0] oh;
          g = 0;
          f = 1'b0;
          for (int k = 1; k <= 2; k++) begin
            int j;
            j = (m_last + k) % 2;
            if (!f && req_valid[j]) begin
              g = j;
              f = 1'b1;
            end
          end
          oh = 2'b01 << g;
          checks++;
          if (req_ready !== oh) begin
            errors++;
            $display("FAIL sb_grant: got %b expected %b", req_ready, oh);
          end
          sbq.push_back({1'(g), fmodel(req_a[32*g +: 32], req_b[32*g +: 32])});
          m_last = g;
        end
        if (resp_valid && resp_ready) begin
          logic [32:0] e;
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL sb_resp: got id=%0d data=%h expected no response",
                     resp_id, resp_data);
          end else begin
            e = sbq.pop_front();
            if ({resp_id, resp_data} !== e) begin
              errors++;
              $display("FAIL sb_resp: got id=%0d data=%h expected id=%0d data=%h",
                       resp_id, resp_data, e[32], e[31:0]);
            end
          end
          exp_ops++;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    req_valid  = 2'b11;
    resp_ready = 1'b0;
    req_a      = {32'h4040_0000, 32'h3F80_0000};
    req_b      = {32'h4000_0000, 32'h4000_0000};
    step();
    step();
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL rst_ready: got %b expected 00", req_ready);
    end
    checks++;
    if ({mul_a, mul_b, resp_data} !== 96'd0) begin
      errors++;
      $display("FAIL rst_data: got a=%h b=%h r=%h expected 0", mul_a, mul_b, resp_data);
    end
    checks++;
    if ({resp_valid, resp_id, busy, ops_done} !== 7'd0) begin
      errors++;
      $display("FAIL rst_ctrl: got v=%b id=%b busy=%b ops=%0d expected 0",
               resp_valid, resp_id, busy, ops_done);
    end
    reset     = 1'b0;
    req_valid = 2'b00;
    step();
  endtask

  task automatic test_single();
    req_valid  = 2'b01;
    resp_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_ready: got %b expected 01", req_ready);
    end
    step();
    req_valid = 2'b00;
    #1;
    checks++;
    if ({busy, resp_valid, mul_a, mul_b} !== {2'b10, 32'h3F80_0000, 32'h4000_0000}) begin
      errors++;
      $display("FAIL single_exec: got busy=%b v=%b a=%h b=%h expected 1 0 3f800000 40000000",
               busy, resp_valid, mul_a, mul_b);
    end
    step();
    checks++;
    if ({resp_valid, resp_id, resp_data} !== {2'b10, 32'h4000_0000}) begin
      errors++;
      $display("FAIL single_resp: got v=%b id=%0d data=%h expected 1 0 40000000",
               resp_valid, resp_id, resp_data);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    checks++;
    if ({resp_valid, busy, ops_done} !== {2'b00, 4'd1}) begin
      errors++;
      $display("FAIL single_done: got v=%b busy=%b ops=%0d expected 0 0 1",
               resp_valid, busy, ops_done);
    end
  endtask

  task automatic test_round_robin();
    int w;
    logic [1:0] oh;
    reset = 1'b1;
    step();
    reset      = 1'b0;
    req_valid  = 2'b11;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_grant(w);
      oh = 2'(1 << (i % 2));
      checks++;
      if (w >= 8 || (i > 0 && w != 2)) begin
        errors++;
        $display("FAIL rr_gap: op %0d waited %0d cycles expected 2", i, w);
      end
      checks++;
      if (req_ready !== oh) begin
        errors++;
        $display("FAIL rr_grant: op %0d got %b expected %b", i, req_ready, oh);
      end
      step();
    end
    req_valid = 2'b00;
    wait_resp(w);
    step();
    checks++;
    if (ops_done !== 4'd4 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_ops: got ops=%0d busy=%b expected 4 0", ops_done, busy);
    end
  endtask

  task automatic test_backpressure();
    int w;
    logic [3:0] ops0;
    resp_ready = 1'b0;
    req_valid  = 2'b10;
    wait_grant(w);
    checks++;
    if (w >= 8 || req_ready !== 2'b10) begin
      errors++;
      $display("FAIL bp_grant: got %b after %0d cycles expected 10", req_ready, w);
    end
    step();
    req_valid = 2'b11;
    step();
    ops0 = 4'(exp_ops);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({resp_valid, resp_id, resp_data, req_ready, busy, ops_done} !==
          {2'b11, 32'h40C0_0000, 2'b00, 1'b1, ops0}) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d got v=%b id=%0d d=%h rdy=%b ops=%0d expected 1 1 40c00000 00 %0d",
                 c, resp_valid, resp_id, resp_data, req_ready, ops_done, ops0);
      end
      step();
    end
    resp_ready = 1'b1;
    req_valid  = 2'b00;
    step();
    resp_ready = 1'b0;
    checks++;
    if ({busy, resp_valid, ops_done} !== {2'b00, 4'(ops0 + 4'd1)}) begin
      errors++;
      $display("FAIL bp_release: got busy=%b v=%b ops=%0d expected 0 0 %0d",
               busy, resp_valid, ops_done, ops0 + 4'd1);
    end
  endtask

  task automatic test_reset_exec();
    int w;
    bit rose;
    req_valid  = 2'b11;
    resp_ready = 1'b0;
    wait_grant(w);
    checks++;
    if (w >= 8 || req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rx_grant: got %b expected 01", req_ready);
    end
    step();
    reset = 1'b1;
    step();
    reset     = 1'b0;
    req_valid = 2'b00;
    checks++;
    if ({busy, resp_valid, ops_done} !== 6'd0) begin
      errors++;
      $display("FAIL rx_state: got busy=%b v=%b ops=%0d expected 0 0 0",
               busy, resp_valid, ops_done);
    end
    rose = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (resp_valid) rose = 1'b1;
      step();
    end
    checks++;
    if (rose) begin
      errors++;
      $display("FAIL rx_norise: got resp_valid=1 expected 0");
    end
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rx_next: got %b expected 01", req_ready);
    end
    resp_ready = 1'b1;
    step();
    req_valid = 2'b00;
    wait_resp(w);
    step();
    resp_ready = 1'b0;
  endtask

  task automatic test_counter_wrap();
    int n;
    n = 0;
    req_valid  = 2'b01;
    resp_ready = 1'b1;
    while (exp_ops < 15 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (ops_done !== 4'd15) begin
      errors++;
      $display("FAIL wrap_top: got %0d expected 15", ops_done);
    end
    while (exp_ops < 16 && n < 200) begin
      step();
      n++;
    end
    req_valid  = 2'b00;
    checks++;
    if (n >= 200 || ops_done !== 4'd0) begin
      errors++;
      $display("FAIL wrap_zero: got %0d after %0d cycles expected 0", ops_done, n);
    end
    step();
    step();
    step();
    resp_ready = 1'b0;
    checks++;
    if (sbq.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending busy=%b expected 0 0", sbq.size(), busy);
    end
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 2'b00;
    resp_ready = 1'b0;
    req_a      = '0;
    req_b      = '0;
    fork
      sb_monitor();
    join_none
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_exec();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
